// File: rtl/bcd_timer_ctrl.sv
// Multi-digit BCD up-counting timer sequencer: start/stop/clear/load control,
// clock prescaler, cascaded decade increment, target compare and wrap detection.
module bcd_timer_ctrl #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned TICK_DIV = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                clear,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_value,
    input  logic [4*DIGITS-1:0] target,
    output logic [4*DIGITS-1:0] count,
    output logic [1:0]          state,
    output logic                running,
    output logic                match,
    output logic                overflow
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StHold = 2'b10,
        StDone = 2'b11
    } state_e;

    localparam logic [15:0] PrescMax = 16'(TICK_DIV - 1);

    state_e              state_q, state_d;
    logic [4*DIGITS-1:0] count_q, count_d;
    logic [15:0]         presc_q, presc_d;
    logic                match_q, match_d;
    logic                overflow_q, overflow_d;

    logic [4*DIGITS-1:0] count_inc;
    logic [4*DIGITS-1:0] load_bcd;
    logic                all_nines;
    logic                carry;
    logic [3:0]          digit;
    logic                tick;

    // Ripple carry across decades; the whole count updates on a single edge.
    always_comb begin
        carry     = 1'b1;
        digit     = 4'd0;
        count_inc = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            digit = count_q[4*i +: 4];
            if (carry) begin
                if (digit == 4'd9) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = digit + 4'd1;
                    carry               = 1'b0;
                end
            end else begin
                count_inc[4*i +: 4] = digit;
            end
        end
        // Carry out of the top digit means every digit was 9.
        all_nines = carry;
    end

    // Non-BCD preload digits are forced to 0 so count stays valid BCD.
    always_comb begin
        load_bcd = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (load_value[4*i +: 4] <= 4'd9) begin
                load_bcd[4*i +: 4] = load_value[4*i +: 4];
            end
        end
    end

    assign tick = (presc_q == PrescMax);

    // Command decode (clear > load > stop > start) and next-state computation.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        presc_d    = presc_q;
        match_d    = 1'b0;
        overflow_d = 1'b0;
        if (clear) begin
            count_d = '0;
            presc_d = '0;
            state_d = StIdle;
        end else if (load && (state_q != StRun)) begin
            count_d = load_bcd;
            presc_d = '0;
            if (state_q == StDone) begin
                state_d = StIdle;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!stop && start) begin
                        state_d = StRun;
                        presc_d = '0;
                    end
                end
                StRun: begin
                    if (stop) begin
                        // Stop beats a coincident tick: count and prescaler freeze.
                        state_d = StHold;
                    end else if (tick) begin
                        presc_d    = '0;
                        count_d    = count_inc;
                        overflow_d = all_nines;
                        // Target digits > 9 can never equal a BCD count.
                        if (count_inc == target) begin
                            match_d = 1'b1;
                            state_d = StDone;
                        end
                    end else begin
                        presc_d = presc_q + 16'd1;
                    end
                end
                StHold: begin
                    if (!stop && start) begin
                        state_d = StRun;
                    end
                end
                StDone: begin
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            count_q    <= '0;
            presc_q    <= '0;
            match_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            presc_q    <= presc_d;
            match_q    <= match_d;
            overflow_q <= overflow_d;
        end
    end

    assign count    = count_q;
    assign state    = state_q;
    assign running  = (state_q == StRun);
    assign match    = match_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Directed bench for bcd_timer_ctrl: two instances (TICK_DIV=1 and TICK_DIV=10)
// share stimulus; expected outputs are queued at drive time and checked after each edge.
module tb_bcd_timer_ctrl;

    localparam logic [1:0] SIdle = 2'b00;
    localparam logic [1:0] SRun  = 2'b01;
    localparam logic [1:0] SHold = 2'b10;
    localparam logic [1:0] SDone = 2'b11;

    logic        clk = 1'b0;
    logic        reset, start, stop, clear, load;
    logic [15:0] load_value, target;

    logic [15:0] count_a, count_b;
    logic [1:0]  state_a, state_b;
    logic        running_a, running_b, match_a, match_b, overflow_a, overflow_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          sel;
        string       tag;
        logic [20:0] exp;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    bcd_timer_ctrl #(.DIGITS(4), .TICK_DIV(1)) dut_a (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .load(load),
        .load_value(load_value), .target(target), .count(count_a), .state(state_a),
        .running(running_a), .match(match_a), .overflow(overflow_a)
    );

    bcd_timer_ctrl #(.DIGITS(4), .TICK_DIV(10)) dut_b (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .load(load),
        .load_value(load_value), .target(target), .count(count_b), .state(state_b),
        .running(running_b), .match(match_b), .overflow(overflow_b)
    );

    function automatic logic [15:0] bcd(input int v);
        logic [15:0] r;
        r[3:0]   = 4'(v % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[15:12] = 4'((v / 1000) % 10);
        return r;
    endfunction

    // Queue the expected post-edge outputs of one instance.
    task automatic expect_out(input int sel, input string tag, input logic [15:0] c,
                              input logic [1:0] st, input logic m, input logic o);
        exp_t e;
        e.sel = sel;
        e.tag = tag;
        e.exp = {c, st, (st == SRun), m, o};
        sb.push_back(e);
    endtask

    // Advance one edge, then pop and compare everything queued.
    task automatic step();
        exp_t        e;
        logic [20:0] obs;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.sel == 0) obs = {count_a, state_a, running_a, match_a, overflow_a};
            else            obs = {count_b, state_b, running_b, match_b, overflow_b};
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h (count,state,running,match,ovf)",
                       e.tag, obs, e.exp);
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0;
        load_value = '0; target = '0;

        // Reset state of both instances.
        expect_out(0, "reset_a", 16'h0000, SIdle, 1'b0, 1'b0);
        expect_out(1, "reset_b", 16'h0000, SIdle, 1'b0, 1'b0);
        step();
        #1;

        // 1: count to 0x0012 at one tick per cycle, then DONE.
        reset = 1'b0; target = 16'h0012; start = 1'b1;
        expect_out(0, "t1_start", 16'h0000, SRun, 1'b0, 1'b0);
        step();
        start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            expect_out(0, $sformatf("t1_cnt%0d", k), bcd(k), (k == 12) ? SDone : SRun,
                       (k == 12), 1'b0);
            step();
        end
        start = 1'b1; stop = 1'b1;
        expect_out(0, "t1_done_hold", 16'h0012, SDone, 1'b0, 1'b0);
        step();
        start = 1'b0; stop = 1'b0;

        // 2: load 0x0999 from DONE, run one tick -> 0x1000.
        load = 1'b1; load_value = 16'h0999;
        expect_out(0, "t2_load", 16'h0999, SIdle, 1'b0, 1'b0);
        step();
        load = 1'b0; target = 16'h5000; start = 1'b1;
        expect_out(0, "t2_start", 16'h0999, SRun, 1'b0, 1'b0);
        step();
        start = 1'b0;
        expect_out(0, "t2_carry", 16'h1000, SRun, 1'b0, 1'b0);
        step();

        // 3: wrap from 9999 with overflow pulse, then match at 0003.
        clear = 1'b1;
        expect_out(0, "t3_clear", 16'h0000, SIdle, 1'b0, 1'b0);
        step();
        clear = 1'b0; load = 1'b1; load_value = 16'h9999;
        expect_out(0, "t3_load", 16'h9999, SIdle, 1'b0, 1'b0);
        step();
        load = 1'b0; target = 16'h0003; start = 1'b1;
        expect_out(0, "t3_start", 16'h9999, SRun, 1'b0, 1'b0);
        step();
        start = 1'b0;
        expect_out(0, "t3_wrap", 16'h0000, SRun, 1'b0, 1'b1);
        step();
        expect_out(0, "t3_c1", 16'h0001, SRun, 1'b0, 1'b0);
        step();
        expect_out(0, "t3_c2", 16'h0002, SRun, 1'b0, 1'b0);
        step();
        expect_out(0, "t3_match", 16'h0003, SDone, 1'b1, 1'b0);
        step();
        expect_out(0, "t3_after", 16'h0003, SDone, 1'b0, 1'b0);
        step();

        // 5: load ignored in RUN, clear beats load, non-BCD preload digits.
        clear = 1'b1;
        expect_out(0, "t5_clear", 16'h0000, SIdle, 1'b0, 1'b0);
        step();
        clear = 1'b0; target = 16'h9000; start = 1'b1;
        expect_out(0, "t5_start", 16'h0000, SRun, 1'b0, 1'b0);
        step();
        start = 1'b0;
        expect_out(0, "t5_c1", 16'h0001, SRun, 1'b0, 1'b0);
        step();
        load = 1'b1; load_value = 16'h0500;
        expect_out(0, "t5_load_in_run", 16'h0002, SRun, 1'b0, 1'b0);
        step();
        clear = 1'b1;
        expect_out(0, "t5_clear_load", 16'h0000, SIdle, 1'b0, 1'b0);
        step();
        clear = 1'b0; load_value = 16'h00A5;
        expect_out(0, "t5_load_a5", 16'h0005, SIdle, 1'b0, 1'b0);
        step();
        load_value = 16'hA5A5;
        expect_out(0, "t5_load_a5a5", 16'h0505, SIdle, 1'b0, 1'b0);
        step();

        // 6: reset mid-RUN at 0x0347 with start held.
        load_value = 16'h0340;
        expect_out(0, "t6_load", 16'h0340, SIdle, 1'b0, 1'b0);
        step();
        load = 1'b0; target = 16'h9999; start = 1'b1;
        expect_out(0, "t6_start", 16'h0340, SRun, 1'b0, 1'b0);
        step();
        start = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            expect_out(0, $sformatf("t6_cnt%0d", k), 16'h0340 + 16'(k), SRun, 1'b0, 1'b0);
            step();
        end
        reset = 1'b1; start = 1'b1;
        expect_out(0, "t6_reset", 16'h0000, SIdle, 1'b0, 1'b0);
        step();
        expect_out(0, "t6_reset_hold", 16'h0000, SIdle, 1'b0, 1'b0);
        step();
        reset = 1'b0; start = 1'b0;
        expect_out(0, "t6_released", 16'h0000, SIdle, 1'b0, 1'b0);
        step();

        // No match without a tick; stop beats a coincident tick.
        target = 16'h0012; load = 1'b1; load_value = 16'h0012;
        expect_out(0, "nm_load", 16'h0012, SIdle, 1'b0, 1'b0);
        step();
        load = 1'b0; start = 1'b1;
        expect_out(0, "nm_start", 16'h0012, SRun, 1'b0, 1'b0);
        step();
        start = 1'b0; stop = 1'b1;
        expect_out(0, "nm_stop_tick", 16'h0012, SHold, 1'b0, 1'b0);
        step();
        stop = 1'b0; start = 1'b1;
        expect_out(0, "nm_restart", 16'h0012, SRun, 1'b0, 1'b0);
        step();
        start = 1'b0;
        expect_out(0, "nm_inc", 16'h0013, SRun, 1'b0, 1'b0);
        step();

        // 4: TICK_DIV=10 prescaler, stop after 15 cycles, resume from held phase.
        clear = 1'b1;
        expect_out(1, "t4_clear", 16'h0000, SIdle, 1'b0, 1'b0);
        step();
        clear = 1'b0; target = 16'h9999; start = 1'b1;
        expect_out(1, "t4_start", 16'h0000, SRun, 1'b0, 1'b0);
        step();
        start = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            expect_out(1, $sformatf("t4_run%0d", k), (k >= 10) ? 16'h0001 : 16'h0000,
                       SRun, 1'b0, 1'b0);
            step();
        end
        stop = 1'b1;
        expect_out(1, "t4_stop", 16'h0001, SHold, 1'b0, 1'b0);
        step();
        stop = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            expect_out(1, $sformatf("t4_hold%0d", k), 16'h0001, SHold, 1'b0, 1'b0);
            step();
        end
        start = 1'b1;
        expect_out(1, "t4_restart", 16'h0001, SRun, 1'b0, 1'b0);
        step();
        start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            expect_out(1, $sformatf("t4_resume%0d", k), (k == 5) ? 16'h0002 : 16'h0001,
                       SRun, 1'b0, 1'b0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
